// File: rtl/pulse_arb_pkg.sv
// Shared types and helpers for the pulse request arbiter: FSM encoding,
// timer width and the round-robin winner search.
package pulse_arb_pkg;

  localparam int unsigned MAX_N = 16;
  localparam int unsigned PTR_W = 4;
  localparam int unsigned TMR_W = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [PTR_W-1:0] idx;
  } rr_pick_t;

  // First set bit of pend searching ptr, ptr+1, ... wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0] pend,
                                       input logic [PTR_W-1:0] ptr,
                                       input int unsigned      n);
    rr_pick_t    r;
    int unsigned j;
    r = '0;
    for (int unsigned k = 0; k < MAX_N; k++) begin
      j = (int'(ptr) + k) % n;
      if (k < n && !r.found && pend[j[PTR_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = j[PTR_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/level_edge_bank.sv
// Per-channel rising-edge detector on synchronized levels. The history register
// resets to all-ones so a level already high at reset release is not an event.
module level_edge_bank #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] lvl_in,
  input  logic [N-1:0] en_mask,
  output logic [N-1:0] rise
);

  logic [N-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q <= '1;
    end else begin
      prev_q <= lvl_in;
    end
  end

  assign rise = lvl_in & ~prev_q & en_mask;

endmodule

// File: rtl/pulse_req_arbiter.sv
// Captures rising edges as pending requests and serves them one at a time,
// round-robin, over a valid/ack handshake with an ack timeout.
module pulse_req_arbiter
  import pulse_arb_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned IDW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   lvl_in,
  input  logic [N-1:0]   en_mask,
  output logic           req_valid,
  output logic [IDW-1:0] req_id,
  input  logic           req_ack,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   ovf,
  input  logic           ovf_clr,
  output logic           timeout_err
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   req_id_q, req_id_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [N-1:0]     ovf_q, ovf_d;
  logic             terr_q, terr_d;
  logic [N-1:0]     rise;
  logic [N-1:0]     clr;
  rr_pick_t         pick;

  level_edge_bank #(
    .N (N)
  ) u_edges (
    .clk     (clk),
    .rst     (rst),
    .lvl_in  (lvl_in),
    .en_mask (en_mask),
    .rise    (rise)
  );

  always_comb begin
    state_d  = state_q;
    req_id_d = req_id_q;
    rr_ptr_d = rr_ptr_q;
    timer_d  = timer_q;
    terr_d   = 1'b0;
    clr      = '0;
    pick     = rr_pick(MAX_N'(pending_q), PTR_W'(rr_ptr_q), N);

    case (state_q)
      S_IDLE: begin
        if (pick.found) begin
          req_id_d = IDW'(pick.idx);
          timer_d  = '0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        // Ack on the final timer cycle still counts as a normal completion.
        if (req_ack || timer_q == TMR_W'(TIMEOUT - 1)) begin
          clr[req_id_q] = 1'b1;
          terr_d        = ~req_ack;
          rr_ptr_d      = (req_id_q == IDW'(N - 1)) ? '0 : req_id_q + 1'b1;
          state_d       = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new rise beats a same-cycle clear; overflow only if it would be lost.
    pending_d = (pending_q & ~clr) | rise;
    ovf_d     = (ovf_clr ? '0 : ovf_q) | (rise & pending_q & ~clr);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      req_id_q  <= '0;
      rr_ptr_q  <= '0;
      timer_q   <= '0;
      pending_q <= '0;
      ovf_q     <= '0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_id_q  <= req_id_d;
      rr_ptr_q  <= rr_ptr_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      terr_q    <= terr_d;
    end
  end

  assign req_valid   = (state_q == S_REQ);
  assign req_id      = req_id_q;
  assign pending     = pending_q;
  assign ovf         = ovf_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_pulse_req_arbiter.sv
// Directed bench for pulse_req_arbiter: a cycle table for reset, latency and
// round-robin order, plus sequences for timeout, overflow, set-wins and reset.
module tb_pulse_req_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] lvl_in;
  logic [3:0] en_mask;
  logic       req_ack;
  logic       ovf_clr;
  logic       req_valid;
  logic [1:0] req_id;
  logic [3:0] pending;
  logic [3:0] ovf;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  pulse_req_arbiter #(
    .N       (4),
    .TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .lvl_in      (lvl_in),
    .en_mask     (en_mask),
    .req_valid   (req_valid),
    .req_id      (req_id),
    .req_ack     (req_ack),
    .pending     (pending),
    .ovf         (ovf),
    .ovf_clr     (ovf_clr),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] lvl;
    logic       ack;
    logic       valid;
    logic [1:0] id;
    logic [3:0] pend;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] l, input logic a,
                     input logic v, input logic [1:0] i, input logic [3:0] p);
    vec_t t;
    t.rst = r; t.lvl = l; t.ack = a; t.valid = v; t.id = i; t.pend = p;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive inputs, clock once, sample 1ns after the edge.
  task automatic step(input logic r, input logic [3:0] l, input logic a, input logic c);
    rst = r; lvl_in = l; req_ack = a; ovf_clr = c;
    @(posedge clk);
    #1;
  endtask

  int vcnt;
  int tcnt;
  int cyc;
  logic saw_fall;

  initial begin
    rst = 1'b0; lvl_in = '0; en_mask = 4'b1111; req_ack = 1'b0; ovf_clr = 1'b0;
    #2;

    // rst, lvl, ack | valid, id, pending (ovf and timeout_err expected 0 throughout)
    add(0, 4'b0000, 0, 0, 0, 4'b0000);
    add(0, 4'b0000, 0, 0, 0, 4'b0000);
    add(1, 4'b0000, 0, 0, 0, 4'b0000);
    // single held level: event, 2-cycle latency, one request only
    add(1, 4'b0001, 0, 0, 0, 4'b0001);
    add(1, 4'b0001, 0, 1, 0, 4'b0001);
    add(1, 4'b0001, 1, 0, 0, 4'b0000);
    add(1, 4'b0001, 0, 0, 0, 4'b0000);
    add(1, 4'b0001, 0, 0, 0, 4'b0000);
    add(1, 4'b0001, 0, 0, 0, 4'b0000);
    add(1, 4'b0000, 0, 0, 0, 4'b0000);
    // fresh reset, then simultaneous 1011: order 0,1,3
    add(0, 4'b0000, 0, 0, 0, 4'b0000);
    add(1, 4'b0000, 0, 0, 0, 4'b0000);
    add(1, 4'b1011, 0, 0, 0, 4'b1011);
    add(1, 4'b1011, 0, 1, 0, 4'b1011);
    add(1, 4'b1011, 1, 0, 0, 4'b1010);
    add(1, 4'b1011, 0, 1, 1, 4'b1010);
    add(1, 4'b1011, 1, 0, 1, 4'b1000);
    add(1, 4'b1011, 0, 1, 3, 4'b1000);
    add(1, 4'b1011, 1, 0, 3, 4'b0000);
    add(1, 4'b0000, 0, 0, 3, 4'b0000);
    // pointer wrapped to 0: ch0 beats ch1
    add(1, 4'b0011, 0, 0, 3, 4'b0011);
    add(1, 4'b0011, 0, 1, 0, 4'b0011);
    add(1, 4'b0011, 1, 0, 0, 4'b0010);
    add(1, 4'b0011, 0, 1, 1, 4'b0010);
    add(1, 4'b0011, 1, 0, 1, 4'b0000);
    add(1, 4'b0000, 0, 0, 1, 4'b0000);
    // ack while idle is ignored
    add(1, 4'b0000, 1, 0, 1, 4'b0000);

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].lvl, vecs[k].ack, 1'b0);
      chk($sformatf("vec%0d {valid,id,pend,ovf,terr}", k),
          {req_valid, req_id, pending, ovf, timeout_err},
          {vecs[k].valid, vecs[k].id, vecs[k].pend, 4'b0000, 1'b0});
    end

    // Timeout on ch2: valid high exactly 15 cycles, one error pulse with the fall
    step(1, 4'b0100, 0, 0);
    chk("to_pending_set", pending, 4'b0100);
    vcnt = 0; tcnt = 0; saw_fall = 1'b0;
    for (cyc = 0; cyc < 40; cyc++) begin
      step(1, 4'b0100, 0, 0);
      if (req_valid) vcnt++;
      if (timeout_err) tcnt++;
      if (!req_valid && vcnt > 0 && !saw_fall) begin
        saw_fall = 1'b1;
        chk("to_err_with_fall", timeout_err, 1'b1);
        chk("to_pending_clr", pending, 4'b0000);
        chk("to_id", req_id, 2'd2);
      end
    end
    chk("to_valid_cycles", vcnt, 15);
    chk("to_err_pulses", tcnt, 1);
    chk("to_fall_seen", saw_fall, 1'b1);

    // Overflow on ch1 while stalled, clear, served once
    step(1, 4'b0000, 0, 0);
    step(1, 4'b0010, 0, 0);
    chk("ov_pend", pending, 4'b0010);
    step(1, 4'b0000, 0, 0);
    chk("ov_req", {req_valid, req_id}, {1'b1, 2'd1});
    step(1, 4'b0010, 0, 0);
    chk("ov_set", ovf, 4'b0010);
    step(1, 4'b0000, 0, 0);
    chk("ov_sticky", ovf, 4'b0010);
    step(1, 4'b0000, 0, 1);
    chk("ov_clr", ovf, 4'b0000);
    step(1, 4'b0000, 1, 0);
    chk("ov_acked", {req_valid, pending}, {1'b0, 4'b0000});
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 4'b0000, 0, 0);
      if (req_valid) vcnt++;
    end
    chk("ov_served_once", vcnt, 0);

    // New ch0 rise on the ack cycle: stays pending, no overflow, re-requested
    step(1, 4'b0001, 0, 0);
    step(1, 4'b0000, 0, 0);
    chk("sw_req", {req_valid, req_id}, {1'b1, 2'd0});
    step(1, 4'b0001, 1, 0);
    chk("sw_set_wins", {req_valid, pending, ovf}, {1'b0, 4'b0001, 4'b0000});
    step(1, 4'b0001, 0, 0);
    chk("sw_second_req", {req_valid, req_id}, {1'b1, 2'd0});
    step(1, 4'b0001, 1, 0);
    chk("sw_done", {req_valid, pending}, {1'b0, 4'b0000});

    // Levels high through reset: no events, enabled or masked
    for (int pass = 0; pass < 2; pass++) begin
      en_mask = (pass == 0) ? 4'b1111 : 4'b0000;
      step(0, 4'b1111, 0, 0);
      step(0, 4'b1111, 0, 0);
      chk($sformatf("rh%0d_reset", pass),
          {req_valid, req_id, pending, ovf, timeout_err}, 12'h000);
      vcnt = 0; tcnt = 0;
      for (int i = 0; i < 10; i++) begin
        step(1, 4'b1111, 0, 0);
        if (req_valid) vcnt++;
        if (pending != 4'b0000) tcnt++;
      end
      chk($sformatf("rh%0d_no_req", pass), vcnt, 0);
      chk($sformatf("rh%0d_no_pend", pass), tcnt, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
